// File: rtl/jtcop_sndcmd_pkg.sv
// Shared types and constants for the main-CPU sound command transmitter.
package jtcop_sndcmd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  localparam int unsigned ST_BUSY = 7;
  localparam int unsigned ST_FULL = 6;
  localparam int unsigned ST_OVF  = 5;
  localparam int unsigned ST_TMO  = 4;
  localparam int unsigned CNT_W   = 4;

  // Clamp a FIFO fill level into the status count field.
  function automatic logic [CNT_W-1:0] sat_count(input logic [31:0] c);
    if (c > 32'd15) return 4'hf;
    return c[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/jtcop_sndcmd_fifo.sv
// Small synchronous first-word-fall-through byte FIFO for queued sound commands.
module jtcop_sndcmd_fifo #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [7:0]       i_din,
  output logic [7:0]       o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [FIFO_AW:0] o_count
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO only fits if the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (FIFO_AW + 1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (FIFO_AW + 1)'(1);
    end
  end

endmodule

// File: rtl/jtcop_sndcmd.sv
// Main-CPU sound command sender: queues CPU bytes, presents them on latch with
// an snreq pulse and waits for the sound CPU's latch-read acknowledge.
module jtcop_sndcmd
  import jtcop_sndcmd_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned REQLEN  = 4,
  parameter int unsigned TOW     = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_cs,
  input  logic       cpu_rnw,
  input  logic [7:0] cpu_dout,
  input  logic       st_rd,
  output logic [7:0] st_dout,
  input  logic       snd_ack,
  output logic [7:0] latch,
  output logic       snreq
);

  localparam int unsigned CW = (REQLEN > 1) ? $clog2(REQLEN) : 1;
  localparam logic [CW-1:0] REQ_LOAD = CW'(REQLEN - 1);

  state_e           r_state, w_state_d;
  logic [7:0]       r_latch, w_latch_d;
  logic             r_snreq, w_snreq_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic             r_ack_seen, w_ack_seen_d;
  logic [TOW-1:0]   r_tmo_cnt, w_tmo_cnt_d;
  logic             r_tmo, w_tmo_d;
  logic             r_ovf, w_ovf_d;
  logic             r_wr_l, r_ack_l, r_st_rd_l;

  logic             w_wr, w_push, w_pop, w_ack_rise, w_st_clr, w_tmo_set;
  logic [7:0]       w_fifo_dout;
  logic             w_full, w_empty, w_busy;
  logic [FIFO_AW:0] w_count;
  logic [TOW-1:0]   w_tmo_inc;

  assign w_wr       = cpu_cs & ~cpu_rnw;
  assign w_push     = w_wr & ~r_wr_l;
  assign w_ack_rise = snd_ack & ~r_ack_l;
  assign w_st_clr   = st_rd & ~r_st_rd_l;
  assign w_tmo_inc  = r_tmo_cnt + TOW'(1);

  jtcop_sndcmd_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (cpu_dout),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_d    = r_state;
    w_latch_d    = r_latch;
    w_snreq_d    = r_snreq;
    w_cnt_d      = r_cnt;
    w_ack_seen_d = r_ack_seen;
    w_tmo_cnt_d  = r_tmo_cnt;
    w_pop        = 1'b0;
    w_tmo_set    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_latch_d = w_fifo_dout;
          w_snreq_d = 1'b1;
          w_cnt_d   = REQ_LOAD;
          w_state_d = StReq;
        end
      end
      StReq: begin
        // An ack arriving while snreq is still high is remembered for WAIT.
        if (w_ack_rise) w_ack_seen_d = 1'b1;
        if (r_cnt == '0) begin
          w_snreq_d   = 1'b0;
          w_tmo_cnt_d = '0;
          w_state_d   = StWait;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      StWait: begin
        if (w_ack_rise || r_ack_seen) begin
          w_ack_seen_d = 1'b0;
          w_state_d    = StIdle;
        end else if (w_tmo_inc == '1) begin
          w_tmo_set = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_tmo_cnt_d = w_tmo_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Sticky flags: a set in the same cycle as the status-read clear wins.
  assign w_ovf_d = (r_ovf & ~w_st_clr) | (w_push & w_full & ~w_pop);
  assign w_tmo_d = (r_tmo & ~w_st_clr) | w_tmo_set;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= StIdle;
      r_latch    <= '0;
      r_snreq    <= 1'b0;
      r_cnt      <= '0;
      r_ack_seen <= 1'b0;
      r_tmo_cnt  <= '0;
      r_tmo      <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_l     <= 1'b0;
      r_ack_l    <= 1'b0;
      r_st_rd_l  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_latch    <= w_latch_d;
      r_snreq    <= w_snreq_d;
      r_cnt      <= w_cnt_d;
      r_ack_seen <= w_ack_seen_d;
      r_tmo_cnt  <= w_tmo_cnt_d;
      r_tmo      <= w_tmo_d;
      r_ovf      <= w_ovf_d;
      r_wr_l     <= w_wr;
      r_ack_l    <= snd_ack;
      r_st_rd_l  <= st_rd;
    end
  end

  assign w_busy  = (r_state != StIdle) | ~w_empty;
  assign latch   = r_latch;
  assign snreq   = r_snreq;
  assign st_dout = {w_busy, w_full, r_ovf, r_tmo, sat_count(32'(w_count))};

endmodule

// File: doc/jtcop_sndcmd.md
Name: jtcop_sndcmd

Overview:
Main-CPU-side sound command transmitter: the sending end of the 8-bit latch + snreq interface consumed by the 6502 sound subsystem. It captures byte writes from the main CPU into a small FIFO, presents each byte on latch, pulses snreq, and then waits for the sound CPU's latch-read acknowledge (its NMI-clear read) before sending the next byte. It sits in the main board glue, between the 68000 bus decoder and the sound module.

Parameters:
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW (legal range 1..3).
REQLEN, 4, number of clk cycles snreq is held high per command (>=1).
TOW, 16, width of the acknowledge timeout counter; timeout = 2**TOW-1 cycles.

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active low
cpu_cs  in  1  main CPU sound-latch chip select
cpu_rnw  in  1  main CPU read/not-write
cpu_dout  in  8  main CPU write data (low byte)
st_rd  in  1  main CPU status-register read strobe
st_dout  out  8  status: [7]busy [6]full [5]ovf [4]tmo [3:0]fifo count
snd_ack  in  1  sound side latch-read indication (level, may last many cycles)
latch  out  8  command byte presented to the sound CPU
snreq  out  1  sound interrupt request to the sound CPU

Behaviour:
- One clock domain. Reset is synchronous and active-low (rstn sampled on posedge clk). During reset and on the first edge after it: latch=0, snreq=0, FIFO empty, count=0, ovf=0, tmo=0, FSM=IDLE, busy=0.
- Write detect: wr = cpu_cs & ~cpu_rnw; only its rising edge (registered wr_l) pushes cpu_dout. Exactly one push per bus cycle, regardless of strobe length.
- Push when full: byte dropped, ovf set (sticky). A push coinciding with a pop while full is accepted; count is unchanged.
- Simultaneous push and pop at any fill level: both occur, count unchanged.
- ovf and tmo clear on the rising edge of st_rd. If a set event occurs in the same cycle as the clear, the set wins.
- st_dout is combinational from the registered state. count saturates into 4 bits and is zero-extended.
- ack edge: ack_rise = snd_ack & ~snd_ack_l.
- FSM:
  IDLE: if FIFO not empty, pop the head into latch, snreq<=1, cnt<=REQLEN-1, go to REQ. Otherwise stay in IDLE.
  REQ: snreq held at 1. A rising ack edge sets ack_seen. When cnt==0: snreq<=0, clear the timeout counter, go to WAIT. Otherwise decrement cnt.
  WAIT: snreq=0. On ack_rise or ack_seen: clear ack_seen, go to IDLE. If the timeout counter reaches all-ones first: set tmo, go to IDLE. Otherwise increment the counter.
- snreq is low for at least 2 cycles between consecutive requests (WAIT >=1 cycle, IDLE 1 cycle), so the receiver's edge detector always sees a fresh rising edge.
- latch holds its value from pop until the next pop, so it stays stable throughout REQ and WAIT.
- Latency: a write edge at cycle t, with the FIFO empty and the FSM in IDLE, gives latch valid and snreq=1 at t+2 (push at t+1, pop at t+2).
- busy = (state!=IDLE) | ~empty.
- An ack edge while in IDLE is ignored.
- rstn asserted mid-transfer aborts everything on that edge: snreq drops and FIFO contents are lost.

Decomposition:
- Package jtcop_sndcmd_pkg holds: the state encoding (IDLE, REQ, WAIT), the status bit positions (ST_BUSY=7, ST_FULL=6, ST_OVF=5, ST_TMO=4), and the count field width.
- Sub-module jtcop_sndcmd_fifo: a synchronous FIFO parameterised by FIFO_AW, with push, pop, din, dout (head, first-word-fall-through), full, empty and count. Push-while-full is accepted only when pop is also asserted.

Test Plan:
- Single command: write 8'h5A and give an ack 10 cycles after snreq falls. Expect latch=5A and snreq high for exactly 4 cycles starting at t+2, then IDLE, busy=0, and st_dout[3:0]=0.
- Burst: write 8'h01..8'h04 back-to-back, each with an 8-cycle strobe, and ack each request. Expect exactly 4 snreq pulses with latch 01, 02, 03, 04 in order, and snreq low >=2 cycles between pulses.
- Overflow with FIFO_AW=2: write 6 bytes with no ack. Expect the first byte sent, 4 held, ovf=1, and one byte (the 6th) dropped. A st_rd edge then clears ovf to 0.
- Timeout with TOW=4: write 8'hA0 and never ack. Expect tmo=1 15 cycles after snreq falls, FSM back in IDLE, and the next queued byte sent.
- Early ack: assert snd_ack during REQ. Expect the FSM to go to IDLE on the cycle after REQ ends, with no timeout. A snd_ack held high for 50 cycles produces only one acknowledge.
- Reset mid-WAIT with 2 bytes queued: drive rstn low for 1 cycle. Expect snreq=0, latch=0, count=0, and no further requests.
